gpio_event_tx: RTL and testbench

Change-driven GPIO transmitter. It synchronizes an asynchronous GPIO input bus and timestamps every change (plus optional periodic heartbeats). It queues the resulting words in a small FIFO and sends them as 32-bit AXI-Stream beats with full valid/ready handshaking. It sits between the board GPIO pins and the 32-bit AXI-Stream GPIO readback path, replacing continuous always-valid sampling with event reporting.

---
 rtl/gpio_event_tx.sv | 132 +++++++++++++
 tb/tb_gpio_event_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_event_tx.sv
// gpio_event_tx: change-driven GPIO sampler that timestamps edges and
// heartbeats, buffers them in a small FIFO and streams them over AXIS.
module gpio_event_tx #(
  parameter int GPIO_W    = 16,
  parameter int DEPTH     = 4,
  parameter int HB_PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic              clr_ovf,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] HB_LAST =
    (HB_PERIOD == 0) ? 32'd0 : 32'(HB_PERIOD - 1);

  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic [GPIO_W-1:0] prev;
  logic [15:0]       ts;
  logic [31:0]       hb;
  logic [15:0]       gpio_ext;
  logic [31:0]       word;
  logic              chg;
  logic              hb_req;
  logic              req;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr_n;
  logic [CW-1:0]     count;
  logic [31:0]       head_n;

  assign m_axis_tvalid = (count != '0);

  // Event detection, FIFO control and next-head selection.
  always_comb begin
    gpio_ext = '0;
    gpio_ext[GPIO_W-1:0] = sync2;
    word   = {ts, gpio_ext};
    chg    = (sync2 != prev);
    hb_req = (HB_PERIOD != 0) && (hb == HB_LAST);
    req    = chg | hb_req;
    full   = (count == CW'(DEPTH));
    pop    = m_axis_tvalid & m_axis_tready;
    push   = req & (~full | pop);
    drop   = req & full & ~pop;
    rptr_n = pop ? rptr + AW'(1) : rptr;
    // A word written into the slot that becomes head must bypass memory.
    if (push && (wptr == rptr_n)) begin
      head_n = word;
    end else begin
      head_n = mem[rptr_n];
    end
  end

  // Two-flop synchronizer plus previous-state history for change detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Free-running timestamp and heartbeat interval counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts <= '0;
      hb <= '0;
    end else begin
      ts <= ts + 16'd1;
      hb <= req ? 32'd0 : hb + 32'd1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rptr <= rptr_n;
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Word storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= word;
    end
  end

  // Registered head of queue, stable while the beat is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata <= '0;
    end else begin
      m_axis_tdata <= head_n;
    end
  end

endmodule

// File: tb/tb_gpio_event_tx.sv
// tb_gpio_event_tx: directed bench with a queue-level reference model
// for two instances (heartbeat off and heartbeat every 8 clocks).
module tb_gpio_event_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ga;
  logic [15:0] gb;
  logic        tra;
  logic        trb;
  logic        clra;
  logic        clrb;
  logic [31:0] tda;
  logic [31:0] tdb;
  logic        tva;
  logic        tvb;
  logic        ova;
  logic        ovb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_event_tx #(.GPIO_W(16), .DEPTH(DEPTH), .HB_PERIOD(0)) dut_a (
    .clk(clk), .rst(rst), .gpio_in(ga), .clr_ovf(clra),
    .m_axis_tdata(tda), .m_axis_tvalid(tva),
    .m_axis_tready(tra), .overflow(ova)
  );

  gpio_event_tx #(.GPIO_W(16), .DEPTH(DEPTH), .HB_PERIOD(8)) dut_b (
    .clk(clk), .rst(rst), .gpio_in(gb), .clr_ovf(clrb),
    .m_axis_tdata(tdb), .m_axis_tvalid(tvb),
    .m_axis_tready(trb), .overflow(ovb)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: list of pending words per instance.
  logic [15:0] ms1 [2];
  logic [15:0] ms2 [2];
  logic [15:0] mpv [2];
  logic [15:0] mts [2];
  int          mhb [2];
  logic [31:0] mf  [2][DEPTH];
  int          msz [2];
  logic        mov [2];

  logic        m_chg;
  logic        m_hbr;
  logic        m_req;
  logic        m_pop;
  logic        m_tr;
  logic        m_clr;
  logic [15:0] m_g;
  int          m_per;
  logic [31:0] m_w;

  // Advance the model one clock using the rules of the block.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ms1[i] = '0; ms2[i] = '0; mpv[i] = '0; mts[i] = '0;
        mhb[i] = 0; msz[i] = 0; mov[i] = 1'b0;
      end else begin
        m_g   = (i == 0) ? ga : gb;
        m_tr  = (i == 0) ? tra : trb;
        m_clr = (i == 0) ? clra : clrb;
        m_per = (i == 0) ? 0 : 8;
        m_chg = (ms2[i] != mpv[i]);
        m_hbr = (m_per != 0) && (mhb[i] == m_per - 1);
        m_req = m_chg || m_hbr;
        m_w   = {mts[i], ms2[i]};
        m_pop = (msz[i] != 0) && m_tr;
        if (m_pop) begin
          for (int k = 0; k < DEPTH - 1; k++) mf[i][k] = mf[i][k+1];
          msz[i]--;
        end
        if (m_req && msz[i] < DEPTH) begin
          mf[i][msz[i]] = m_w;
          msz[i]++;
        end
        if (m_req && msz[i] == DEPTH && !(mf[i][DEPTH-1] === m_w))
          mov[i] = 1'b1;
        else if (m_clr)
          mov[i] = 1'b0;
        mhb[i] = m_req ? 0 : mhb[i] + 1;
        mts[i] = mts[i] + 16'd1;
        mpv[i] = ms2[i];
        ms2[i] = ms1[i];
        ms1[i] = m_g;
      end
    end
  end

  // Compare outputs against the model every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_tvalid%0d", i),
          32'((i == 0) ? tva : tvb), 32'(msz[i] != 0));
      chk($sformatf("model_overflow%0d", i),
          32'((i == 0) ? ova : ovb), 32'(mov[i]));
      if (msz[i] != 0)
        chk($sformatf("model_tdata%0d", i),
            (i == 0) ? tda : tdb, mf[i][0]);
    end
  end

  // Record accepted beats.
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  always @(posedge clk) begin
    if (!rst) begin
      if (tva && tra) qa.push_back(tda);
      if (tvb && trb) qb.push_back(tdb);
    end
  end

  int          n;
  int          hits;
  logic [31:0] v;
  logic [15:0] d;
  logic [15:0] tc;

  initial begin
    ga = 16'h00A5; gb = 16'h0003;
    tra = 1'b1; trb = 1'b1; clra = 1'b0; clrb = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tvalid", 32'(tva), 0);
    chk("reset_tdata", tda, 0);
    chk("reset_overflow", 32'(ova), 0);
    rst = 1'b0;

    n = 0;
    while (qa.size() == 0 && n < 20) begin
      @(negedge clk); n++;
    end
    v = (qa.size() > 0) ? qa[0] : 32'hDEADBEEF;
    chk("init_word", v, 32'h0002_00A5);
    repeat (20) @(negedge clk);
    chk("init_word_count", 32'(qa.size()), 1);

    ga = 16'h0000;
    repeat (6) @(negedge clk);
    tra = 1'b0;
    repeat (2) @(negedge clk);
    qa.delete();
    ga = 16'h0001;
    @(negedge clk);
    chk("lat_e0", 32'(tva), 0);
    @(negedge clk);
    chk("lat_e1", 32'(tva), 0);
    @(negedge clk);
    chk("lat_e2", 32'(tva), 1);
    chk("lat_data", 32'(tda[15:0]), 1);
    v = tda;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(tva), 1);
      chk("stall_data", tda, v);
    end
    tra = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'(tva), 0);
    chk("stall_beats", 32'(qa.size()), 1);

    tra = 1'b0;
    qa.delete();
    for (int k = 0; k < 6; k++) begin
      ga[0] = ~ga[0];
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("ovf_set", 32'(ova), 1);
    tra = 1'b1;
    repeat (8) @(negedge clk);
    tra = 1'b0;
    chk("ovf_drain_count", 32'(qa.size()), 4);
    if (qa.size() == 4) begin
      for (int k = 0; k < 4; k++)
        chk("ovf_drain_data", 32'(qa[k][15:0]), (k % 2 == 0) ? 0 : 1);
      for (int k = 1; k < 4; k++) begin
        d = qa[k][31:16] - qa[k-1][31:16];
        chk("ovf_ts_step", 32'(d), 2);
      end
    end
    clra = 1'b1;
    @(negedge clk);
    clra = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 32'(ova), 0);

    qa.delete();
    for (int k = 0; k < 4; k++) begin
      ga[0] = ~ga[0];
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("full_no_ovf", 32'(ova), 0);
    ga[0] = ~ga[0];
    repeat (2) @(negedge clk);
    tra = 1'b1;
    @(negedge clk);
    tra = 1'b0;
    repeat (4) @(negedge clk);
    chk("fullpop_ovf", 32'(ova), 0);
    chk("fullpop_one_beat", 32'(qa.size()), 1);
    tra = 1'b1;
    repeat (8) @(negedge clk);
    chk("fullpop_total", 32'(qa.size()), 5);
    v = (qa.size() == 5) ? 32'(qa[4][15:0]) : 32'hDEADBEEF;
    chk("fullpop_last", v, 0);

    v = (qb.size() > 2) ? qb[0] : 32'hDEADBEEF;
    chk("hb_first", v, 32'h0002_0003);
    v = (qb.size() > 2) ? qb[1] : 32'hDEADBEEF;
    chk("hb_second", v, 32'h000A_0003);
    v = (qb.size() > 2) ? qb[2] : 32'hDEADBEEF;
    chk("hb_third", v, 32'h0012_0003);
    n = 0;
    while (mts[1][2:0] != 3'd0 && n < 20) begin
      @(negedge clk); n++;
    end
    tc = mts[1] + 16'd2;
    gb = 16'h0007;
    repeat (20) @(negedge clk);
    hits = 0;
    foreach (qb[k]) begin
      if (qb[k][31:16] == tc) begin
        hits++;
        chk("hb_coinc_data", 32'(qb[k][15:0]), 7);
      end
      if (qb[k][31:16] == tc - 16'd8)
        chk("hb_before", 32'(qb[k][15:0]), 3);
      if (qb[k][31:16] == tc + 16'd8)
        chk("hb_after", 32'(qb[k][15:0]), 7);
    end
    chk("hb_coinc_once", 32'(hits), 1);

    tra = 1'b0;
    qa.delete();
    for (int k = 0; k < 3; k++) begin
      ga[0] = ~ga[0];
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("rst_queued", 32'(tva), 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_tvalid", 32'(tva), 0);
    ga = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tra = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_discard", 32'(qa.size()), 0);

    n = 0;
    while (mts[0] != 16'hFFFF && n < 70000) begin
      @(negedge clk); n++;
    end
    chk("wrap_reached", 32'(mts[0]), 32'h0000_FFFF);
    qa.delete();
    ga = 16'h0005;
    repeat (6) @(negedge clk);
    chk("wrap_count", 32'(qa.size()), 1);
    v = (qa.size() > 0) ? qa[0] : 32'hDEADBEEF;
    chk("wrap_word", v, 32'h0001_0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
